// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: counter width default and standard VGA mode segment lengths
// shared by the timing generator and its axis counters.
package vga_timing_pkg;

    localparam int VGA_CW_DEFAULT = 11;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } seg_t;

    localparam seg_t H_640  = '{active: 640,  fp: 16, sync: 96,  bp: 48};
    localparam seg_t V_480  = '{active: 480,  fp: 10, sync: 2,   bp: 33};
    localparam seg_t H_800  = '{active: 800,  fp: 40, sync: 128, bp: 88};
    localparam seg_t V_600  = '{active: 600,  fp: 1,  sync: 4,   bp: 23};
    localparam seg_t H_1024 = '{active: 1024, fp: 24, sync: 136, bp: 160};
    localparam seg_t V_768  = '{active: 768,  fp: 3,  sync: 6,   bp: 29};

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (active, front porch, sync, back porch)
// with combinational segment decode of the current count.
module vga_axis_counter #(
    parameter int CW     = 11,
    parameter int ACTIVE = 1024,
    parameter int FP     = 24,
    parameter int SYNC   = 136,
    parameter int BP     = 160,
    parameter bit POL    = 1'b0
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          active,
    output logic          sync,
    output logic          wrap
);

    localparam int TOTAL   = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_LO = ACTIVE + FP;
    localparam int SYNC_HI = ACTIVE + FP + SYNC;

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_seg_err
        $error("vga_axis_counter: every segment length must be at least 1");
    end
    if (TOTAL > 2 ** CW) begin : g_width_err
        $error("vga_axis_counter: total length does not fit in CW bits");
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + 1'b1;
    end

    // compare in 32 bits so ACTIVE == 2**CW does not alias to zero
    always_comb begin
        wrap   = 32'(count) == TOTAL - 1;
        active = 32'(count) < ACTIVE;
        sync   = (32'(count) >= SYNC_LO && 32'(count) < SYNC_HI) ? POL : ~POL;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with one pixel of output latency.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CW        = VGA_CW_DEFAULT,
    parameter int H_ACTIVE  = H_1024.active,
    parameter int H_FP      = H_1024.fp,
    parameter int H_SYNC    = H_1024.sync,
    parameter int H_BP      = H_1024.bp,
    parameter int V_ACTIVE  = V_768.active,
    parameter int V_FP      = V_768.fp,
    parameter int V_SYNC    = V_768.sync,
    parameter int V_BP      = V_768.bp,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          sol,
    output logic          sof
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    logic [CW-1:0] hc, vc;
    logic h_act, v_act, h_sync, v_sync, h_wrap;
    logic act;

    vga_axis_counter #(
        .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)
    ) u_h (
        .clk(clk), .clr_n(clr_n), .en(pix_en),
        .count(hc), .active(h_act), .sync(h_sync), .wrap(h_wrap)
    );

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic v_wrap;
`endif

    vga_axis_counter #(
        .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)
    ) u_v (
        .clk(clk), .clr_n(clr_n), .en(pix_en && h_wrap),
        .count(vc), .active(v_act), .sync(v_sync),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .wrap(v_wrap)
`else
        .wrap()
`endif
    );

    assign act = h_act && v_act;

    // pulses are cleared on every clk so they stay one clk wide when pix_en is sparse
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            de    <= 1'b0;
            x     <= '0;
            y     <= '0;
            hsync <= ~HSYNC_POL;
            vsync <= ~VSYNC_POL;
            sol   <= 1'b0;
            sof   <= 1'b0;
        end else begin
            sol <= pix_en && hc == '0;
            sof <= pix_en && hc == '0 && vc == '0;
            if (pix_en) begin
                de    <= act;
                x     <= act ? hc : '0;
                y     <= act ? vc : '0;
                hsync <= h_sync;
                vsync <= v_sync;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            frame_cnt <= '0;
        else if (pix_en && h_wrap && v_wrap)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vector table plus multi-cycle sequences for a
// small 8x6 raster and the default 1024x768 timing.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic clr_n_d = 1'b0;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    logic hsync, vsync, de, sol, sof;
    logic [3:0] x, y;
    logic d_hsync, d_vsync, d_de, d_sol, d_sof;
    logic [10:0] d_x, d_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt, d_frame_cnt;
`endif

    vga_timing_gen #(
        .CW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk(clk), .clr_n(clr_n), .pix_en(pix_en),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y), .sol(sol), .sof(sof)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    vga_timing_gen dut_d (
        .clk(clk), .clr_n(clr_n_d), .pix_en(1'b1),
        .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .x(d_x), .y(d_y), .sol(d_sol), .sof(d_sof)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(d_frame_cnt)
`endif
    );

    typedef struct packed {
        logic       de;
        logic [3:0] x;
        logic [3:0] y;
        logic       hs;
        logic       vs;
        logic       sol;
        logic       sof;
    } outs_t;

    typedef struct {
        logic  pe;
        outs_t exp;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    vec_t vecs[12];
    outs_t rst_val;

    function automatic outs_t mk(bit d, int xx, int yy, bit hs, bit vs, bit sl, bit sf);
        outs_t o;
        o.de = d; o.x = 4'(xx); o.y = 4'(yy); o.hs = hs; o.vs = vs; o.sol = sl; o.sof = sf;
        return o;
    endfunction

    function automatic outs_t cur();
        return {de, x, y, hsync, vsync, sol, sof};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_small();
        clr_n = 1'b0;
        pix_en = 1'b0;
        tick();
        tick();
        clr_n = 1'b1;
    endtask

    initial begin
        int t, line_p, de_c, hs_c, vs_c, sol_c, sof_c, first, second, first_low;
        rst_val = mk(0, 0, 0, 1, 1, 0, 0);
        vecs[0]  = '{1'b1, mk(1, 0, 0, 1, 1, 1, 1)};
        vecs[1]  = '{1'b0, mk(1, 0, 0, 1, 1, 0, 0)};
        vecs[2]  = '{1'b1, mk(1, 1, 0, 1, 1, 0, 0)};
        vecs[3]  = '{1'b1, mk(1, 2, 0, 1, 1, 0, 0)};
        vecs[4]  = '{1'b1, mk(1, 3, 0, 1, 1, 0, 0)};
        vecs[5]  = '{1'b1, mk(0, 0, 0, 1, 1, 0, 0)};
        vecs[6]  = '{1'b1, mk(0, 0, 0, 0, 1, 0, 0)};
        vecs[7]  = '{1'b0, mk(0, 0, 0, 0, 1, 0, 0)};
        vecs[8]  = '{1'b1, mk(0, 0, 0, 0, 1, 0, 0)};
        vecs[9]  = '{1'b1, mk(0, 0, 0, 1, 1, 0, 0)};
        vecs[10] = '{1'b1, mk(1, 0, 1, 1, 1, 1, 0)};
        vecs[11] = '{1'b1, mk(1, 1, 1, 1, 1, 0, 0)};

        reset_small();
        chk("reset_state", 32'(cur()), 32'(rst_val));
        for (int i = 0; i < 12; i++) begin
            pix_en = vecs[i].pe;
            tick();
            chk($sformatf("vec%0d", i), 32'(cur()), 32'(vecs[i].exp));
        end

        // continuous pix_en: one full frame of the 8x6 raster
        reset_small();
        pix_en = 1'b1;
        tick();
        chk("frame_first_sof", 32'(sof), 32'd1);
        de_c = 32'(de); hs_c = 32'(!hsync); vs_c = 32'(!vsync); sol_c = 32'(sol);
        line_p = 0; t = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (sof) begin t = k; break; end
            if (sol && line_p == 0) line_p = k;
            de_c += 32'(de); hs_c += 32'(!hsync); vs_c += 32'(!vsync); sol_c += 32'(sol);
        end
        chk("frame_period", 32'(t), 32'd48);
        chk("line_period", 32'(line_p), 32'd8);
        chk("frame_de_count", 32'(de_c), 32'd12);
        chk("frame_hsync_low", 32'(hs_c), 32'd12);
        chk("frame_vsync_low", 32'(vs_c), 32'd8);
        chk("frame_sol_count", 32'(sol_c), 32'd6);

        // pix_en one clk in four
        reset_small();
        sol_c = 0; sof_c = 0; first = -1; second = -1;
        for (int i = 0; i < 200; i++) begin
            pix_en = (i % 4 == 0);
            tick();
            if (sol) begin
                sol_c++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (sof) sof_c++;
        end
        chk("sparse_line_period", 32'(second - first), 32'd32);
        chk("sparse_sol_width", 32'(sol_c), 32'd7);
        chk("sparse_sof_width", 32'(sof_c), 32'd2);

        // asynchronous reset inside the active area, then in the hsync pulse at (5,2)
        reset_small();
        pix_en = 1'b1;
        repeat (11) tick();
        chk("pre_rst_active", 32'(cur()), 32'(mk(1, 2, 1, 1, 1, 0, 0)));
        #2 clr_n = 1'b0;
        #1 chk("async_rst_active", 32'(cur()), 32'(rst_val));
        tick();
        clr_n = 1'b1;
        repeat (22) tick();
        chk("pre_rst_hsync", 32'(cur()), 32'(mk(0, 0, 0, 0, 1, 0, 0)));
        #2 clr_n = 1'b0;
        #1 chk("async_rst_hsync", 32'(cur()), 32'(rst_val));
        tick();
        tick();
        chk("rst_held", 32'(cur()), 32'(rst_val));
        clr_n = 1'b1;
        tick();
        chk("restart_origin", 32'(cur()), 32'(mk(1, 0, 0, 1, 1, 1, 1)));
        tick();
        chk("restart_next", 32'(cur()), 32'(mk(1, 1, 0, 1, 1, 0, 0)));

`ifdef VGA_TIMING_FRAME_CNT_EN
        reset_small();
        pix_en = 1'b1;
        repeat (10) tick();
        chk("fc_reset", 32'(frame_cnt), 32'd0);
        force dut.frame_cnt = 16'hFFFE;
        #1 release dut.frame_cnt;
        sof_c = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (sof) begin
                sof_c++;
                if (sof_c == 1) chk("fc_ffff", 32'(frame_cnt), 32'hFFFF);
                else begin chk("fc_wrap", 32'(frame_cnt), 32'd0); break; end
            end
        end
        chk("fc_frames_seen", 32'(sof_c), 32'd2);
`endif

        // default 1024x768 timing
        clr_n_d = 1'b1;
        tick();
        chk("def_first_sof", 32'({d_sol, d_sof}), 32'd3);
        t = 0; first_low = -1; hs_c = 0;
        for (int k = 1; k <= 2000; k++) begin
            tick();
            if (d_sol) begin t = k; break; end
            if (!d_hsync) begin hs_c++; if (first_low < 0) first_low = k; end
        end
        chk("def_line_period", 32'(t), 32'd1344);
        chk("def_hsync_start", 32'(first_low), 32'd1048);
        chk("def_hsync_width", 32'(hs_c), 32'd136);
        // jump to line 770 to reach vsync and the frame wrap in a bounded run
        force dut_d.u_v.count = 11'd770;
        #1 release dut_d.u_v.count;
        t = 0; vs_c = 0;
        for (int k = 1; k <= 60000; k++) begin
            tick();
            if (d_sof) begin t = k; break; end
            vs_c += 32'(!d_vsync);
        end
        chk("def_frame_wrap", 32'(t), 32'd48384);
        chk("def_vsync_low", 32'(vs_c), 32'd8064);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
